// File: rtl/bus_gate_mux.sv
// Registered bus selector: priority-resolved one-hot gating onto a shared bus,
// one output stage with valid/ready handshake and a saturating conflict counter.
module bus_gate_mux #(
    parameter int WIDTH     = 16,
    parameter int NUM_SRC   = 4,
    parameter int SRC_W     = 2,
    parameter int CNT_W     = 8,
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_SRC*WIDTH-1:0] Data_In,
    input  logic [NUM_SRC-1:0]       Gate,
    input  logic                     Out_Ready,
    output logic                     In_Ready,
    output logic [WIDTH-1:0]         Out_Data,
    output logic                     Out_Valid,
    output logic [SRC_W-1:0]         Out_Src,
    output logic                     Conflict,
    output logic [CNT_W-1:0]         Conflict_Count
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             cap;
    logic             any_gate;
    logic             multi_gate;
    logic [SRC_W-1:0] sel;
    logic [WIDTH-1:0] win_data;

    assign In_Ready   = !out_valid_q | Out_Ready;
    assign cap        = In_Ready & !Reset;
    assign any_gate   = |Gate;
    // Clearing the lowest set bit leaves something only if two or more gates are set.
    assign multi_gate = (Gate & (Gate - NUM_SRC'(1))) != '0;

    // Scan high to low so the lowest set index is the last, winning assignment.
    always_comb begin
        sel      = '0;
        win_data = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (Gate[i]) begin
                sel      = SRC_W'(i);
                win_data = Data_In[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        conflict_d  = 1'b0;
        count_d     = count_q;
        if (cap) begin
            if (any_gate) begin
                out_data_d  = win_data;
                out_src_d   = sel;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
                if (!HOLD_LAST) out_data_d = '0;
            end
            if (multi_gate) begin
                conflict_d = 1'b1;
                if (count_q != '1) count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            conflict_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            conflict_q  <= conflict_d;
            count_q     <= count_d;
        end
    end

    assign Out_Data       = out_data_q;
    assign Out_Valid      = out_valid_q;
    assign Out_Src        = out_src_q;
    assign Conflict       = conflict_q;
    assign Conflict_Count = count_q;

endmodule

// File: tb/tb_bus_gate_mux.sv
// Scoreboard bench: two bus_gate_mux instances (defaults, and CNT_W=2/HOLD_LAST=0)
// share stimulus; a reference model queues expected words, a monitor pops and checks.
module tb_bus_gate_mux;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [63:0] Data_In;
    logic [3:0]  Gate;
    logic        Out_Ready;

    logic        in_rdy_a, vld_a, conf_a, in_rdy_b, vld_b, conf_b;
    logic [15:0] data_a, data_b;
    logic [1:0]  src_a, src_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    always #5 Clk = ~Clk;

    bus_gate_mux u_a (
        .Clk(Clk), .Reset(Reset), .Data_In(Data_In), .Gate(Gate), .Out_Ready(Out_Ready),
        .In_Ready(in_rdy_a), .Out_Data(data_a), .Out_Valid(vld_a), .Out_Src(src_a),
        .Conflict(conf_a), .Conflict_Count(cnt_a)
    );

    bus_gate_mux #(.CNT_W(2), .HOLD_LAST(1'b0)) u_b (
        .Clk(Clk), .Reset(Reset), .Data_In(Data_In), .Gate(Gate), .Out_Ready(Out_Ready),
        .In_Ready(in_rdy_b), .Out_Data(data_b), .Out_Valid(vld_b), .Out_Src(src_b),
        .Conflict(conf_b), .Conflict_Count(cnt_b)
    );

    typedef struct {
        logic [15:0] d;
        logic [1:0]  s;
    } item_t;

    item_t       exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          started = 0;

    // Reference state, written only by the stimulus process right after each edge.
    bit          m_valid;
    bit          m_conf;
    int          m_cnt_a, m_cnt_b;
    logic [15:0] m_data_a, m_data_b;
    logic [1:0]  m_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int ones, sel;
        logic [15:0] w;
        if (Reset) begin
            m_valid = 0; m_conf = 0; m_cnt_a = 0; m_cnt_b = 0;
            m_data_a = '0; m_data_b = '0; m_src = '0;
            exp_q.delete();
        end else if (!m_valid || Out_Ready) begin
            ones = $countones(Gate);
            if (ones > 0) begin
                sel = 0;
                while (!Gate[sel]) sel++;
                w = Data_In[sel*16 +: 16];
                exp_q.push_back('{d: w, s: 2'(sel)});
                m_valid = 1; m_data_a = w; m_data_b = w; m_src = 2'(sel);
            end else begin
                m_valid = 0; m_data_b = '0;
            end
            m_conf = (ones >= 2);
            if (m_conf) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3)   m_cnt_b++;
            end
        end else begin
            m_conf = 0;
        end
    endtask

    // Drive inputs, let the edge happen, advance the model, then move off the edge.
    task automatic cyc(input logic r, input logic [3:0] g, input logic ordy);
        Reset = r; Gate = g; Out_Ready = ordy;
        @(posedge Clk);
        model_step();
        started = 1;
        #2;
    endtask

    always @(negedge Clk) begin
        if (started) begin
            chk("in_ready_a", 32'(in_rdy_a), 32'(!m_valid || Out_Ready));
            chk("in_ready_b", 32'(in_rdy_b), 32'(!m_valid || Out_Ready));
            chk("valid_a", 32'(vld_a), 32'(m_valid));
            chk("valid_b", 32'(vld_b), 32'(m_valid));
            chk("conflict_a", 32'(conf_a), 32'(m_conf));
            chk("conflict_b", 32'(conf_b), 32'(m_conf));
            chk("count_a", 32'(cnt_a), 32'(m_cnt_a));
            chk("count_b", 32'(cnt_b), 32'(m_cnt_b));
            chk("data_a", 32'(data_a), 32'(m_data_a));
            chk("data_b", 32'(data_b), 32'(m_data_b));
            chk("src_a", 32'(src_a), 32'(m_src));
            chk("src_b", 32'(src_b), 32'(m_src));
            if (vld_a && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL xfer_empty: got word %h expected none at %0t", data_a, $time);
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    chk("xfer_data_a", 32'(data_a), 32'(it.d));
                    chk("xfer_data_b", 32'(data_b), 32'(it.d));
                    chk("xfer_src", 32'(src_a), 32'(it.s));
                end
            end
        end
    end

    initial begin
        Reset = 1'b1; Gate = '0; Out_Ready = 1'b1;
        Data_In = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        #2;
        // Reset and idle
        cyc(1, 4'b0000, 1); cyc(1, 4'b0000, 1);
        repeat (3) cyc(0, 4'b0000, 1);
        // One-hot walk
        cyc(0, 4'b0001, 1); cyc(0, 4'b0010, 1); cyc(0, 4'b0100, 1); cyc(0, 4'b1000, 1);
        cyc(0, 4'b0000, 1);
        // Backpressure: capture C, stall 3 cycles with gate 0001 presented, release
        cyc(0, 4'b0100, 0);
        repeat (3) cyc(0, 4'b0001, 0);
        cyc(0, 4'b0001, 1); cyc(0, 4'b0000, 1);
        // Conflicts
        cyc(1, 4'b0000, 1);
        cyc(0, 4'b0110, 1); cyc(0, 4'b0000, 1); cyc(0, 4'b1010, 1); cyc(0, 4'b0000, 1);
        // Saturation on the narrow counter, back-to-back conflicts
        repeat (5) cyc(0, 4'b1111, 1);
        cyc(0, 4'b0000, 1);
        // Conflict during a stall is not counted
        cyc(0, 4'b0001, 0); cyc(0, 4'b0011, 0); cyc(0, 4'b0000, 1);
        // Reset mid-stall
        cyc(0, 4'b0100, 0); cyc(0, 4'b0100, 0); cyc(1, 4'b0100, 0); cyc(0, 4'b0000, 1);
        // Gate=0 after a capture: zero-load on one instance, hold on the other
        cyc(0, 4'b0010, 1); cyc(0, 4'b0000, 1); cyc(0, 4'b0000, 1);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] g;
            int kind;
            Data_In = {$urandom, $urandom};
            kind = $urandom_range(0, 9);
            if (kind < 2)      g = 4'b0000;
            else if (kind < 7) g = 4'(1 << $urandom_range(0, 3));
            else               g = 4'($urandom);
            cyc(($urandom_range(0, 99) == 0), g, ($urandom_range(0, 9) < 7));
        end
        cyc(0, 4'b0000, 1); cyc(0, 4'b0000, 1);
        @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
